// File: rtl/bus_arbiter_pkg.sv
// Shared types and defaults for the two-requester memory bus arbiter.
// Requester indices map A to 0 and B to 1 throughout the design.
package bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_ACCESS  = 2'b01,
        ST_RELEASE = 2'b10
    } arb_state_t;

    localparam int DEF_ADDR_W  = 32;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_TIMEOUT = 15;

    localparam int REQ_A = 0;
    localparam int REQ_B = 1;

    // A disabled timeout (0) still needs a 1-bit counter to keep widths legal.
    function automatic int cnt_width(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// Combinational two-way round-robin grant: on a tie the requester not served last wins.
module rr_arbiter_2
    import bus_arbiter_pkg::*;
(
    input  logic       i_req_a,
    input  logic       i_req_b,
    input  logic       i_last_b,
    output logic [1:0] o_grant
);

    always_comb begin
        o_grant = 2'b00;
        if (i_req_a && i_req_b) begin
            o_grant[REQ_A] = i_last_b;
            o_grant[REQ_B] = !i_last_b;
        end else if (i_req_a) begin
            o_grant[REQ_A] = 1'b1;
        end else if (i_req_b) begin
            o_grant[REQ_B] = 1'b1;
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Arbitrates two requesters onto one memory bus: IDLE grants, ACCESS holds the strobe
// until Ready or timeout, RELEASE waits for Ready to fall. Every output is a register.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              A_Req,
    input  logic              A_Write,
    input  logic [ADDR_W-1:0] A_Address,
    input  logic [DATA_W-1:0] A_Data_Out,
    output logic [DATA_W-1:0] A_Data_In,
    output logic              A_Ack,
    output logic              A_Err,
    input  logic              B_Req,
    input  logic              B_Write,
    input  logic [ADDR_W-1:0] B_Address,
    input  logic [DATA_W-1:0] B_Data_Out,
    output logic [DATA_W-1:0] B_Data_In,
    output logic              B_Ack,
    output logic              B_Err,
    output logic              Bus_Mem_Read,
    output logic              Bus_Mem_Write,
    output logic [ADDR_W-1:0] Bus_Mem_Address,
    output logic [DATA_W-1:0] Bus_Mem_Data_Out,
    input  logic [DATA_W-1:0] Bus_Mem_Data_In,
    input  logic              Bus_Mem_Ready
);

    localparam int CNT_W = cnt_width(TIMEOUT);

    arb_state_t        r_state, w_state_next;
    logic [CNT_W-1:0]  r_cnt, w_cnt_next;
    logic              r_gnt_b, w_gnt_b_next;
    logic              r_last_b, w_last_b_next;
    logic              r_rd, w_rd_next;
    logic              r_wr, w_wr_next;
    logic [ADDR_W-1:0] r_addr, w_addr_next;
    logic [DATA_W-1:0] r_wdata, w_wdata_next;

    logic [1:0]        w_grant;
    logic              w_sel_write;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_data;
    logic              w_ready_done;
    logic              w_timeout;
    logic [1:0]        w_ack;
    logic [1:0]        w_err;
    logic [DATA_W-1:0] w_data_in [2];

    rr_arbiter_2 u_rr (
        .i_req_a  (A_Req),
        .i_req_b  (B_Req),
        .i_last_b (r_last_b),
        .o_grant  (w_grant)
    );

    assign w_sel_write = w_grant[REQ_B] ? B_Write    : A_Write;
    assign w_sel_addr  = w_grant[REQ_B] ? B_Address  : A_Address;
    assign w_sel_data  = w_grant[REQ_B] ? B_Data_Out : A_Data_Out;

    // Ready takes priority: a timeout only fires when Ready is low in the same cycle.
    assign w_ready_done = (r_state == ST_ACCESS) && Bus_Mem_Ready;
    assign w_timeout    = (TIMEOUT != 0) && (r_state == ST_ACCESS) && !Bus_Mem_Ready &&
                          ((int'(r_cnt) + 1) == TIMEOUT);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_gnt_b  <= 1'b0;
            r_last_b <= 1'b1;
            r_rd     <= 1'b0;
            r_wr     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
        end else begin
            r_state  <= w_state_next;
            r_cnt    <= w_cnt_next;
            r_gnt_b  <= w_gnt_b_next;
            r_last_b <= w_last_b_next;
            r_rd     <= w_rd_next;
            r_wr     <= w_wr_next;
            r_addr   <= w_addr_next;
            r_wdata  <= w_wdata_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_cnt_next    = r_cnt;
        w_gnt_b_next  = r_gnt_b;
        w_last_b_next = r_last_b;
        w_rd_next     = r_rd;
        w_wr_next     = r_wr;
        w_addr_next   = r_addr;
        w_wdata_next  = r_wdata;
        case (r_state)
            ST_IDLE: begin
                if (|w_grant) begin
                    w_gnt_b_next = w_grant[REQ_B];
                    w_rd_next    = !w_sel_write;
                    w_wr_next    = w_sel_write;
                    w_addr_next  = w_sel_addr;
                    w_wdata_next = w_sel_data;
                    w_cnt_next   = '0;
                    w_state_next = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                w_cnt_next = r_cnt + 1'b1;
                if (w_ready_done || w_timeout) begin
                    w_rd_next    = 1'b0;
                    w_wr_next    = 1'b0;
                    w_state_next = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (!Bus_Mem_Ready) begin
                    w_last_b_next = r_gnt_b;
                    w_state_next  = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Per-requester completion registers; only the granted side ever pulses or loads.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_req
            logic              r_ack;
            logic              r_err;
            logic [DATA_W-1:0] r_data_in;
            logic              w_is_gnt;

            assign w_is_gnt = (r_gnt_b == 1'(gi));

            always_ff @(posedge clk) begin
                if (!reset) begin
                    r_ack     <= 1'b0;
                    r_err     <= 1'b0;
                    r_data_in <= '0;
                end else begin
                    r_ack <= w_is_gnt && (w_ready_done || w_timeout);
                    r_err <= w_is_gnt && w_timeout;
                    if (w_is_gnt && w_ready_done && r_rd) begin
                        r_data_in <= Bus_Mem_Data_In;
                    end
                end
            end

            assign w_ack[gi]     = r_ack;
            assign w_err[gi]     = r_err;
            assign w_data_in[gi] = r_data_in;
        end
    endgenerate

    assign A_Ack            = w_ack[REQ_A];
    assign B_Ack            = w_ack[REQ_B];
    assign A_Err            = w_err[REQ_A];
    assign B_Err            = w_err[REQ_B];
    assign A_Data_In        = w_data_in[REQ_A];
    assign B_Data_In        = w_data_in[REQ_B];
    assign Bus_Mem_Read     = r_rd;
    assign Bus_Mem_Write    = r_wr;
    assign Bus_Mem_Address  = r_addr;
    assign Bus_Mem_Data_Out = r_wdata;

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32: address width.
REQ-002 Parameter DATA_W, default 32: data width.
REQ-003 Parameter TIMEOUT, default 15: max ACCESS cycles without Ready; 0 disables timeout.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-low reset.
REQ-006 A_Req / B_Req  in  1  requester A / B access request, level.
REQ-007 A_Write / B_Write  in  1  1 = write, 0 = read; sampled with Req.
REQ-008 A_Address / B_Address  in  ADDR_W  access address.
REQ-009 A_Data_Out / B_Data_Out  in  DATA_W  write data.
REQ-010 A_Data_In / B_Data_In  out  DATA_W  read data returned to requester.
REQ-011 A_Ack / B_Ack  out  1  one-cycle completion pulse.
REQ-012 A_Err / B_Err  out  1  one-cycle pulse with Ack on timeout.
REQ-013 Bus_Mem_Read / Bus_Mem_Write  out  1  memory strobes.
REQ-014 Bus_Mem_Address  out  ADDR_W; Bus_Mem_Data_Out  out  DATA_W: address and write data to memory.
REQ-015 Bus_Mem_Data_In  in  DATA_W; Bus_Mem_Ready  in  1: memory read data and valid/done.

Function
REQ-016 States SHALL be IDLE, ACCESS and RELEASE; all outputs SHALL be registered.
REQ-017 IDLE: with any Req high, SHALL grant one requester, latch its Write/Address/Data_Out into Bus_Mem_* and enter ACCESS; the strobe SHALL be high in the cycle after Req is sampled.
REQ-018 Both Req high in IDLE: SHALL grant the requester not served last (round-robin); after reset A wins the first tie.
REQ-019 ACCESS: strobe, address and write data SHALL stay stable; requester input changes SHALL be ignored.
REQ-020 Bus_Mem_Ready sampled 1 in ACCESS: SHALL drop the strobe, pulse granted X_Ack for exactly one cycle, load Bus_Mem_Data_In into X_Data_In on reads only, and enter RELEASE.
REQ-021 Timeout counter, width clog2(TIMEOUT+1), SHALL clear on entering ACCESS and increment each ACCESS cycle; on reaching TIMEOUT without Ready, SHALL drop the strobe, pulse X_Ack and X_Err together, and enter RELEASE.
REQ-022 Ready and timeout in the same cycle: Ready wins; no Err.
REQ-023 RELEASE: SHALL stay until Bus_Mem_Ready is 0, then go to IDLE and record the served requester as last-granted.
REQ-024 Req dropped mid-ACCESS: the access SHALL complete normally, including the Ack pulse.
REQ-025 Req still high when IDLE is re-entered SHALL be treated as a new request.
REQ-026 X_Data_In SHALL hold its value until the next read completes for that requester; timeouts leave it unchanged.
REQ-027 Minimum turnaround per access SHALL be 3 cycles: IDLE, ACCESS and RELEASE, one cycle each.

Reset
REQ-028 reset low at a clock edge SHALL force IDLE, timeout counter 0, last-granted = B, and all outputs 0, including Data_In buses.
REQ-029 Reset mid-ACCESS SHALL abandon the access: strobes drop at that edge and no Ack or Err is issued.

Structure
REQ-030 State encodings (IDLE=2'b00, ACCESS=2'b01, RELEASE=2'b10) and default widths SHALL live in shared package bus_arbiter_pkg.
REQ-031 Grant selection SHALL be a sub-module rr_arbiter_2 (two requests plus last-granted in; one-hot grant out), combinational.

Verification
Bench memory model: returns Address+6 and asserts Ready 3 cycles after the strobe; Ready drops 1 cycle after the strobe drops.
REQ-032 A read only, A_Address=0x10: Bus_Mem_Read high next cycle; A_Ack pulses once with A_Data_In=0x16; B outputs stay 0.
REQ-033 A and B reading together (0x20, 0x40): A served first (0x26), then B (0x46); next tie grants A.
REQ-034 B write, B_Address=0x8, B_Data_Out=0xDEADBEEF: Bus_Mem_Write high with those values held stable; B_Ack pulses; B_Data_In unchanged.
REQ-035 Memory never Ready, TIMEOUT=15: strobe high exactly 15 cycles, then A_Ack=A_Err=1 for one cycle; state returns to IDLE.
REQ-036 reset low during ACCESS: outputs 0 on the next edge, no Ack; after reset release, a fresh A read completes correctly.
